src_mem_ctrl: RTL
=================

# src_mem_ctrl

Clocked, parametrised memory-interface controller for the SRC datapath. It holds the MA (address) and MD (data) registers and runs single-word read/write transactions against an external memory over a request/acknowledge handshake, which tolerates variable memory latency. It sits between the CPU internal bus and the memory port and replaces the level-sensitive combinational MA/MD latch design with a registered, handshaked one.

## Interface
Parameters:
- AW, 16, address width (MA width); MA loads from cpu_din[AW-1:0]
- DW, 32, data width (MD, CPU bus, memory data)
- TIMEOUT_CYCLES, 15, cycles allowed in REQ before abort; used only with SRC_MEM_TIMEOUT_EN

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- cpu_din  in  DW  CPU bus value into MA/MD
- cpu_dout  out  DW  MD contents toward CPU bus
- cpu_oe  out  1  CPU bus drive enable, equal to md_out
- ma_in  in  1  load MA on this edge
- md_in  in  1  load MD from cpu_din on this edge
- md_out  in  1  request MD on CPU bus
- start  in  1  begin transaction (sampled in IDLE only)
- read  in  1  direction at start: 1 = read, 0 = write
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle timeout pulse, coincident with done; tied 0 without the macro
- mem_addr  out  AW  address to memory, = MA
- mem_wdata  out  DW  write data, = MD
- mem_rdata  in  DW  read data, valid with mem_ack
- mem_req  out  1  request, high throughout REQ
- mem_we  out  1  write strobe, high in REQ for writes only
- mem_ack  in  1  memory completion, sampled in REQ only

## Operation
- States: IDLE, REQ, DONE.
- IDLE: ma_in loads MA; md_in loads MD. If start=1, latch read into dir and go to REQ.
- REQ: mem_req=1, mem_we=~dir. On mem_ack: if dir=read, MD <= mem_rdata; go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- ma_in/md_in in REQ or DONE: ignored. MA/MD remain stable for the entire transaction.
- ma_in, md_in, and start in the same IDLE cycle: registers load and start is accepted. The transaction uses the newly loaded values.
- mem_ack outside REQ: ignored.
- cpu_oe/cpu_dout are combinational from md_out and MD. They are valid in every state.

## Timing
- Reset values: MA=0, MD=0, state=IDLE, busy=0, done=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_oe follows md_out.
- start sampled at edge k: mem_req high from edge k to the edge where mem_ack is sampled.
- mem_ack present at the first REQ edge: done is high in the cycle after, i.e. minimum start-to-done is 2 edges.
- Read data is visible on cpu_dout in the DONE cycle.
- Reset asserted mid-transaction: immediate return to the reset values. mem_req drops asynchronously. No done pulse.

## Configuration
- SRC_MEM_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and increments each REQ cycle.
  - If the count reaches TIMEOUT_CYCLES with mem_ack low, go to DONE with err=1; MD is unchanged.
  - mem_ack on the expiry cycle wins: normal completion, err=0.
- SRC_MEM_TIMEOUT_EN undefined: REQ waits indefinitely, err is constant 0, and no counter is synthesised.

## Structure
- Package src_mem_pkg: state enum (IDLE, REQ, DONE), default AW/DW constants, TIMEOUT_CYCLES default.
- Sub-module src_mem_timer (clear, count-enable, expired output, $clog2(TIMEOUT_CYCLES+1)-bit counter). It is instantiated only under SRC_MEM_TIMEOUT_EN.

## Test plan
- Reset with md_out=1 -> cpu_dout=0, cpu_oe=1, mem_req=0, busy=0.
- Write: ma_in with cpu_din=0x0000_1234, md_in with 0xDEAD_BEEF, start with read=0, ack after 3 REQ cycles -> mem_addr=0x1234, mem_wdata=0xDEADBEEF, mem_we=1 for 3 cycles, single done pulse.
- Read: MA=0x00FF, start with read=1, ack with mem_rdata=0xCAFE_F00D on the first REQ edge -> done 2 edges after start, cpu_dout=0xCAFEF00D.
- md_in=1 with cpu_din=0x1111_1111 during REQ -> MD and mem_wdata unchanged; spurious mem_ack in IDLE -> no state change.
- rst pulse during REQ -> mem_req=0 immediately, MA=MD=0, no done.
- With SRC_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4:
  - No ack -> done=err=1 after 4 REQ cycles, MD unchanged.
  - Ack on the 4th REQ cycle -> err=0.

Source files
------------

// File: rtl/src_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : src_mem_pkg
// Description : Shared types and default sizes for the SRC memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package src_mem_pkg;

  localparam int c_DEFAULT_AW             = 16;
  localparam int c_DEFAULT_DW             = 32;
  localparam int c_DEFAULT_TIMEOUT_CYCLES = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/src_mem_timer.sv
`default_nettype none
// ============================================================================
// Module      : src_mem_timer
// Description : REQ-phase watchdog; flags the cycle on which the wait expires.
// Revision    : 1.0 - initial release
// ============================================================================
module src_mem_timer
  import src_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_cnt_en,
  output logic o_expired
);

  localparam int              c_CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT_CYCLES - 1);

  logic [c_CW-1:0] r_count;

  // Count holds the number of REQ cycles already completed, so expiry is
  // seen during the TIMEOUT_CYCLES-th REQ cycle.
  assign o_expired = i_cnt_en && (r_count == c_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_cnt_en && !o_expired) begin
      r_count <= r_count + c_CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/src_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : src_mem_ctrl
// Description : Registered MA/MD with a req/ack single-word memory handshake.
//               Optional REQ timeout enabled by SRC_MEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module src_mem_ctrl
  import src_mem_pkg::*;
#(
  parameter int AW             = c_DEFAULT_AW,
  parameter int DW             = c_DEFAULT_DW,
  parameter int TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_oe,
  input  logic          ma_in,
  input  logic          md_in,
  input  logic          md_out,
  input  logic          start,
  input  logic          read,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_req,
  output logic          mem_we,
  input  logic          mem_ack
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_ma;
  logic [DW-1:0] r_md;
  logic          r_dir;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef SRC_MEM_TIMEOUT_EN
  logic w_expired;
  logic w_timeout;
  logic r_err;

  src_mem_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (r_state != REQ),
    .i_cnt_en  (r_state == REQ),
    .o_expired (w_expired)
  );

  // Registered so the pulse lines up with the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_timeout;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
`ifdef SRC_MEM_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      IDLE: if (start) w_state_nxt = REQ;
      REQ: begin
        // An ack on the expiry cycle still completes normally.
        if (mem_ack) begin
          w_state_nxt = DONE;
        end
`ifdef SRC_MEM_TIMEOUT_EN
        else if (w_expired) begin
          w_state_nxt = DONE;
          w_timeout   = 1'b1;
        end
`endif
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // MA/MD only accept CPU loads in IDLE, so they are frozen for a transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ma  <= '0;
      r_md  <= '0;
      r_dir <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ma_in) r_ma  <= cpu_din[AW-1:0];
          if (md_in) r_md  <= cpu_din;
          if (start) r_dir <= read;
        end
        REQ: if (mem_ack && r_dir) r_md <= mem_rdata;
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign mem_req   = (r_state == REQ);
  assign mem_we    = mem_req && !r_dir;
  assign mem_addr  = r_ma;
  assign mem_wdata = r_md;
  assign cpu_dout  = r_md;
  assign cpu_oe    = md_out;

endmodule
`default_nettype wire
